// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the program loader and the control decoder:
// operation kinds, opcodes, field positions and loader states.
package cpu_isa_pkg;

  // Kinds 14 and 15 are unassigned and rejected as illegal.
  typedef enum logic [3:0] {
    OP_ALU  = 4'd0,
    OP_LI   = 4'd1,
    OP_LUI  = 4'd2,
    OP_ADDI = 4'd3,
    OP_ANDI = 4'd4,
    OP_ORI  = 4'd5,
    OP_LB   = 4'd6,
    OP_SB   = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_B    = 4'd12,
    OP_NOP  = 4'd13
  } op_kind_t;

  localparam logic [5:0] OPC_ALU  = 6'b100000;
  localparam logic [5:0] OPC_LI   = 6'b111000;
  localparam logic [5:0] OPC_LUI  = 6'b111001;
  localparam logic [5:0] OPC_ADDI = 6'b110000;
  localparam logic [5:0] OPC_ANDI = 6'b110010;
  localparam logic [5:0] OPC_ORI  = 6'b110011;
  localparam logic [5:0] OPC_LB   = 6'b000011;
  localparam logic [5:0] OPC_SB   = 6'b000111;
  localparam logic [5:0] OPC_LW   = 6'b001111;
  localparam logic [5:0] OPC_SW   = 6'b011111;
  localparam logic [5:0] OPC_BEQ  = 6'b000000;
  localparam logic [5:0] OPC_BNE  = 6'b000001;
  localparam logic [5:0] OPC_B    = 6'b111111;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RD_LSB  = 16;
  localparam int RT_LSB  = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } ld_state_t;

  function automatic logic [5:0] kind_opcode(input logic [3:0] kind);
    case (kind)
      OP_ALU:  return OPC_ALU;
      OP_LI:   return OPC_LI;
      OP_LUI:  return OPC_LUI;
      OP_ADDI: return OPC_ADDI;
      OP_ANDI: return OPC_ANDI;
      OP_ORI:  return OPC_ORI;
      OP_LB:   return OPC_LB;
      OP_SB:   return OPC_SB;
      OP_LW:   return OPC_LW;
      OP_SW:   return OPC_SW;
      OP_BEQ:  return OPC_BEQ;
      OP_BNE:  return OPC_BNE;
      OP_B:    return OPC_B;
      default: return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: operation kind plus fields -> 32-bit instruction word,
// with a legality flag for unassigned kinds.
module instr_field_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  input  logic [15:0] immed,
  input  logic [3:0]  func,
  output logic [31:0] word,
  output logic        legal
);

  logic [5:0] opc;

  always_comb begin
    opc   = kind_opcode(kind);
    word  = '0;
    legal = 1'b1;
    case (kind)
      OP_ALU:  word = {opc, rs, rd, rt, 7'b0, func};
      // Load-immediate forms never carry a source register.
      OP_LI, OP_LUI: word = {opc, 5'b0, rd, immed};
      OP_ADDI, OP_ANDI, OP_ORI, OP_LB, OP_SB, OP_LW, OP_SW, OP_BEQ, OP_BNE:
        word = {opc, rs, rd, immed};
      OP_B:    word = {opc, 10'b0, immed};
      OP_NOP:  word = '0;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction descriptions over valid/ready, packs them
// and writes them to consecutive instruction-memory words.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for a description (ready unless full/start)
//   ST_ENCODE | packed word captured, moved to the write data register
//   ST_WRITE  | imem_wren high for this cycle, then addr/count advance
//   ST_DONE   | last instruction written, loader closed until start/rst
module instr_encoder_loader
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rt,
  input  logic [15:0]       in_immed,
  input  logic [3:0]        in_func,
  input  logic              in_last,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wrdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d, count_inc;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              wren_q, wren_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       wrdata_q, wrdata_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;

  instr_field_pack u_pack (
    .kind  (in_kind),
    .rs    (in_rs),
    .rd    (in_rd),
    .rt    (in_rt),
    .immed (in_immed),
    .func  (in_func),
    .word  (pack_word),
    .legal (pack_legal)
  );

  assign in_ready  = ~rst & ~start & (state_q == ST_IDLE) & ~full_q;
  assign accept    = in_valid & in_ready;
  assign count_inc = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    full_d   = full_q;
    done_d   = done_q;
    err_d    = 1'b0;
    last_d   = last_q;
    wren_d   = 1'b0;
    word_d   = word_q;
    wrdata_d = wrdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (pack_legal) begin
            word_d  = pack_word;
            last_d  = in_last;
            state_d = ST_ENCODE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ENCODE: begin
        wrdata_d = word_q;
        wren_d   = 1'b1;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        count_d = count_inc;
        // Address saturates at the top word so it never wraps past DEPTH.
        if (count_inc == DEPTH_C) full_d = 1'b1;
        else                      addr_d = addr_q + ADDR_W'(1);
        if (last_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wren_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      wren_q   <= 1'b0;
      word_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      done_q   <= done_d;
      err_q    <= err_d;
      last_q   <= last_d;
      wren_q   <= wren_d;
      word_q   <= word_d;
      wrdata_q <= wrdata_d;
    end
  end

  // A start landing on the WRITE cycle discards that word.
  assign imem_wren   = wren_q & ~start & ~rst;
  assign imem_addr   = addr_q;
  assign imem_wrdata = wrdata_q;
  assign count       = count_q;
  assign full        = full_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule
